trace_req_issuer: RTL and testbench

//  Consumer of parsed trace records (time, core, op, address) delivered over a valid/ready stream.

---
 rtl/trace_req_issuer_pkg.sv | 46 ++++
 rtl/trace_req_issuer_if.sv | 50 +++++
 rtl/trace_req_issuer_fifo.sv | 82 ++++++++
 rtl/trace_req_issuer.sv | 124 ++++++++++++
 tb/tb_trace_req_issuer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_req_issuer_pkg.sv
// ============================================================================
// Package  : trace_pkg
// Purpose  : Shared types and constants for the trace request issuer: the
//            op encoding, the buffered trace record and the DRAM address
//            field positions used by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int TRACE_TIME_W = 64;
  localparam int TRACE_ADDR_W = 36;
  localparam int CORE_W       = 12;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  // 'time' is a keyword, so the stamp field carries a longer name.
  typedef struct packed {
    logic [TRACE_TIME_W-1:0] time_stamp;
    logic [CORE_W-1:0]       core;
    op_e                     op;
    logic [TRACE_ADDR_W-1:0] addr;
  } trace_req_t;

  // DRAM field positions inside the byte address
  localparam int ROW_MSB    = 33;
  localparam int ROW_LSB    = 18;
  localparam int COL_HI_MSB = 17;
  localparam int COL_HI_LSB = 12;
  localparam int BANK_MSB   = 11;
  localparam int BANK_LSB   = 10;
  localparam int BG_MSB     = 9;
  localparam int BG_LSB     = 7;
  localparam int CHAN_BIT   = 6;
  localparam int COL_LO_MSB = 5;
  localparam int COL_LO_LSB = 4;

endpackage

`default_nettype wire

// File: rtl/trace_req_issuer_if.sv
// ============================================================================
// Interface : trace_req_issuer_if
// Purpose   : Record input stream and decoded request output stream of the
//             trace request issuer.
//   slave  modport : issuer view (consumes records, presents requests)
//   master modport : producer/consumer view (testbench or neighbours)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trace_req_issuer_if #(
  parameter int TIME_W = 64,
  parameter int ADDR_W = 36
);

  // record input stream
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic [11:0]       in_core;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_addr;

  // request output stream
  logic              out_valid;
  logic              out_ready;
  logic [11:0]       out_core;
  logic [1:0]        out_op;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_row;
  logic [7:0]        out_col;
  logic [1:0]        out_bank;
  logic [2:0]        out_bg;
  logic              out_chan;

  modport slave (
    input  in_valid, in_time, in_core, in_op, in_addr, out_ready,
    output in_ready, out_valid, out_core, out_op, out_addr,
           out_row, out_col, out_bank, out_bg, out_chan
  );

  modport master (
    output in_valid, in_time, in_core, in_op, in_addr, out_ready,
    input  in_ready, out_valid, out_core, out_op, out_addr,
           out_row, out_col, out_bank, out_bg, out_chan
  );

endinterface

`default_nettype wire

// File: rtl/trace_req_issuer_fifo.sv
// ============================================================================
// Module   : trace_req_fifo
// Purpose  : Synchronous FIFO of trace records with registered storage.
// Ports    : clk, rst_n (async active-low)
//            push_i/data_i  - write a record (ignored when full)
//            pop_i          - drop the head record (ignored when empty)
//            data_o         - head record
//            full_o/empty_o - occupancy flags
//            count_o        - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_req_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  trace_req_t             data_i,
  input  logic                   pop_i,
  output trace_req_t             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // Power-of-two depth lets the pointers wrap naturally; count separates
  // the full and empty cases where the pointers are equal.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is reset too so the head-driven outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trace_req_issuer.sv
// ============================================================================
// Module   : trace_req_issuer
// Purpose  : Buffers parsed trace records and releases each one once the
//            free-running cycle counter reaches its time stamp; the released
//            address is sliced into DRAM row/col/bank/bank-group/channel.
// Ports    : clk, rst_n (async active-low)
//            bus       - record input stream and request output stream
//            cycle_cnt - current simulation time (saturating)
//            count     - buffered records
//            order_err - pulse: accepted time stamp went backwards
//            op_err    - pulse: reserved op consumed and dropped
// Config   : TRACE_TIME_SKIP_EN - when defined, an idle counter jumps
//            straight to the head record's time stamp.
// Note     : TIME_W/ADDR_W must match the trace_pkg record widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_req_issuer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TIME_W = TRACE_TIME_W,
  parameter int ADDR_W = TRACE_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  trace_req_issuer_if.slave      bus,
  output logic [TIME_W-1:0]      cycle_cnt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   order_err,
  output logic                   op_err
);

  trace_req_t        push_rec;
  trace_req_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              due;
  logic [TIME_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic              order_err_q, order_err_d;
  logic              op_err_q, op_err_d;

  assign push_rec = '{time_stamp: bus.in_time,
                      core:       bus.in_core,
                      op:         op_e'(bus.in_op),
                      addr:       bus.in_addr};

  // Reserved ops are consumed from the stream but never buffered.
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && (op_e'(bus.in_op) != OP_RSVD);
  assign due    = (cycle_cnt_q >= head.time_stamp);
  assign pop    = bus.out_valid && bus.out_ready;

  trace_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // A full FIFO refuses input even when the head leaves in the same cycle.
  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty && due;
  assign bus.out_core  = head.core;
  assign bus.out_op    = head.op;
  assign bus.out_addr  = head.addr;
  assign bus.out_row   = head.addr[ROW_MSB:ROW_LSB];
  assign bus.out_col   = {head.addr[COL_HI_MSB:COL_HI_LSB], head.addr[COL_LO_MSB:COL_LO_LSB]};
  assign bus.out_bank  = head.addr[BANK_MSB:BANK_LSB];
  assign bus.out_bg    = head.addr[BG_MSB:BG_LSB];
  assign bus.out_chan  = head.addr[CHAN_BIT];

  assign cycle_cnt = cycle_cnt_q;
  assign order_err = order_err_q;
  assign op_err    = op_err_q;

`ifdef TRACE_TIME_SKIP_EN
  // Extra bit keeps cycle_cnt+1 from wrapping at the saturation point.
  logic [TIME_W:0] cnt_plus_one;
  assign cnt_plus_one = {1'b0, cycle_cnt_q} + {{TIME_W{1'b0}}, 1'b1};
`endif

  always_comb begin
    cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
`ifdef TRACE_TIME_SKIP_EN
    if (!fifo_empty && !due && ({1'b0, head.time_stamp} > cnt_plus_one)) begin
      cycle_cnt_d = head.time_stamp;
    end
`endif
  end

  always_comb begin
    order_err_d = accept && (bus.in_time < last_time_q);
    op_err_d    = accept && (op_e'(bus.in_op) == OP_RSVD);
    last_time_d = accept ? bus.in_time : last_time_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      last_time_q <= '0;
      order_err_q <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      last_time_q <= last_time_d;
      order_err_q <= order_err_d;
      op_err_q    <= op_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trace_req_issuer.sv
// ============================================================================
// Module   : tb_trace_req_issuer
// Purpose  : Self-checking bench for trace_req_issuer: directed scenarios
//            followed by randomized records, checked every cycle against a
//            queue-based reference model of the issuer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trace_req_issuer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int TW    = 64;
  localparam int AW    = 36;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  trace_req_issuer_if #(.TIME_W(TW), .ADDR_W(AW)) bus ();
  logic [TW-1:0]          cycle_cnt;
  logic [$clog2(DEPTH):0] count;
  logic                   order_err;
  logic                   op_err;

  trace_req_issuer #(.DEPTH(DEPTH), .TIME_W(TW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cycle_cnt (cycle_cnt),
    .count     (count),
    .order_err (order_err),
    .op_err    (op_err)
  );

  typedef struct {
    logic [63:0] t;
    logic [11:0] core;
    logic [1:0]  op;
    logic [35:0] addr;
  } rec_t;

  rec_t        sb[$];
  logic [63:0] m_cnt;
  logic [63:0] m_last;
  bit          m_oerr;
  bit          m_perr;
  int          total = 0;
  int          bad   = 0;
  bit          rnd_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model + monitor: compares every output each cycle, then
  // advances the model across the coming rising edge.
  always @(negedge clk) begin : monitor
    bit          due;
    bit          acc;
    logic [63:0] nxt;
    logic [63:0] a;
    if (!rst_n) begin
      sb.delete();
      m_cnt  = '0;
      m_last = '0;
      m_oerr = 0;
      m_perr = 0;
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      chk("rst_out_core", bus.out_core, 0);
      chk("rst_errs", {order_err, op_err}, 0);
    end else begin
      due = (sb.size() > 0) && (m_cnt >= sb[0].t);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      chk("count", count, sb.size());
      chk("in_ready", bus.in_ready, sb.size() != DEPTH);
      chk("out_valid", bus.out_valid, due);
      chk("order_err", order_err, m_oerr);
      chk("op_err", op_err, m_perr);
      if (due && bus.out_valid) begin
        a = 64'(sb[0].addr);
        chk("out_core", bus.out_core, sb[0].core);
        chk("out_op", bus.out_op, sb[0].op);
        chk("out_addr", bus.out_addr, a);
        chk("out_row", bus.out_row, (a >> 18) & 64'hFFFF);
        chk("out_col", bus.out_col, (((a >> 12) & 64'h3F) << 2) | ((a >> 4) & 64'h3));
        chk("out_bank", bus.out_bank, (a >> 10) & 64'h3);
        chk("out_bg", bus.out_bg, (a >> 7) & 64'h7);
        chk("out_chan", bus.out_chan, (a >> 6) & 64'h1);
      end
      // next counter value from the pre-edge queue state
      nxt = (m_cnt == '1) ? m_cnt : m_cnt + 64'd1;
`ifdef TRACE_TIME_SKIP_EN
      if (sb.size() > 0 && !due && sb[0].t > m_cnt + 64'd1) nxt = sb[0].t;
`endif
      acc = bus.in_valid && (sb.size() != DEPTH);
      if (due && bus.out_ready) void'(sb.pop_front());
      if (acc && bus.in_op != 2'd3)
        sb.push_back('{t: bus.in_time, core: bus.in_core, op: bus.in_op, addr: bus.in_addr});
      m_oerr = acc && (bus.in_time < m_last);
      m_perr = acc && (bus.in_op == 2'd3);
      if (acc) m_last = bus.in_time;
      m_cnt = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.out_ready = ($urandom % 4) != 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one record and hold it until the issuer takes it.
  task automatic send(input logic [63:0] t, input int core, input int op, input logic [35:0] a);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_time  = t;
    bus.in_core  = 12'(core);
    bus.in_op    = 2'(op);
    bus.in_addr  = a;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        break;
      end
      tick();
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no in_ready expected accept (t=%0t)", $time);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait at falling edges for out_valid; a timeout counts as a failure.
  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got no out_valid expected one within %0d cycles", name, bound);
    end
  endtask

  initial begin : stim
    logic [63:0] t;
    bus.in_valid  = 1'b0;
    bus.in_time   = '0;
    bus.in_core   = '0;
    bus.in_op     = '0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // first issue exactly at its time stamp, with decoded fields
    bus.out_ready = 1'b1;
    send(64'd5, 1, 0, 36'h0_0004_0C80);
    wait_valid("t1_wait", 50);
    chk("t1_first_cnt", cycle_cnt, 5);
    chk("t1_row", bus.out_row, 16'h0001);
    chk("t1_bank", bus.out_bank, 3);
    chk("t1_bg", bus.out_bg, 1);
    chk("t1_chan", bus.out_chan, 0);
    tick();

    // two due records held while stalled, then issued back to back
    bus.out_ready = 1'b0;
    send(64'd0, 2, 1, 36'h1_2345_6789);
    send(64'd0, 3, 2, 36'h8_7654_3210);
    idle(5);
    @(negedge clk);
    chk("t2_held_count", count, 2);
    chk("t2_held_valid", bus.out_valid, 1);
    tick();
    bus.out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("t2_drained", count, 0);
    tick();

    // fill to full, 17th refused, room reappears after a pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(64'd100, i, i % 3, 36'({$urandom, $urandom}));
    @(negedge clk);
    chk("t3_full_ready", bus.in_ready, 0);
    chk("t3_full_count", count, DEPTH);
    tick();
    bus.in_valid = 1'b1;
    bus.in_time  = 64'd100;
    bus.in_core  = 12'd77;
    bus.in_op    = 2'd1;
    bus.in_addr  = 36'h0_ABCD_EF00;
    idle(3);
    @(negedge clk);
    chk("t3_refused", count, DEPTH);
    wait_valid("t3_wait", 200);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t3_ready_back", bus.in_ready, 1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(20);

    // backwards time stamp: flagged, stored in arrival order, due at once
    bus.out_ready = 1'b0;
    send(64'd50, 8, 0, 36'h0_0000_1000);
    send(64'd20, 9, 1, 36'h0_0000_2000);
    idle(2);
    bus.out_ready = 1'b1;
    idle(4);

    // reserved op: consumed, flagged, never issued
    send(64'd0, 5, 3, 36'h0_0000_3000);
    idle(3);
    @(negedge clk);
    chk("t5_count", count, 0);
    chk("t5_valid", bus.out_valid, 0);
    tick();

    // reset while records are queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(cycle_cnt + 64'd5000, i, 0, 36'(i * 64));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_cnt", cycle_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // far-future record: issued when cycle_cnt reaches 1000
    idle(2);
    bus.out_ready = 1'b1;
    send(64'd1000, 10, 2, 36'h0_0010_0040);
    wait_valid("t6_wait", 1500);
    chk("t6_issue_cnt", cycle_cnt, 1000);
    tick();

    // randomized records with random back-pressure
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom % 3);
      t = cycle_cnt + 64'($urandom % 25);
      if (($urandom % 8) == 0) t = cycle_cnt - 64'($urandom % 10);
      send(t, $urandom % 4096, (($urandom % 10) == 0) ? 3 : ($urandom % 3),
           36'({$urandom, $urandom}));
    end
    rnd_ready = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 500 && count != 0; n++) tick();
    @(negedge clk);
    chk("final_empty", count, 0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
